// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
//   Shared definitions for the UART transmit arbiter: FSM state encoding,
//   word width, the largest supported requester count and the wrap helper
//   used by the round-robin search.
// ---------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arb_st_t;

    // Reduce an index in [0, 2n) back into [0, n). The round-robin search
    // never goes past one full lap, so a single subtraction is enough.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the producer-side valid/ready handshakes and the transmitter
//   side (data_in / data_valid / busy / ready) plus grant status.
//
//   Producer side : in_data[NUM_REQ][32], in_valid[NUM_REQ], in_ready[NUM_REQ]
//   Transmitter   : tx_data[32], tx_valid, tx_busy, tx_ready
//   Status        : grant_id[ID_W], done
//
//   slave  : the arbiter itself
//   master : the environment (producers + transmitter)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0][WORD_W-1:0] in_data;
    logic [NUM_REQ-1:0]             in_valid;
    logic [NUM_REQ-1:0]             in_ready;

    logic [WORD_W-1:0]              tx_data;
    logic                           tx_valid;
    logic                           tx_busy;
    logic                           tx_ready;

    logic [ID_W-1:0]                grant_id;
    logic                           done;

    modport slave (
        input  in_data, in_valid, tx_busy, tx_ready,
        output in_ready, tx_data, tx_valid, grant_id, done
    );

    modport master (
        output in_data, in_valid, tx_busy, tx_ready,
        input  in_ready, tx_data, tx_valid, grant_id, done
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin selector. The search starts one past
//   the previous winner and wraps; the first set request bit wins.
//
//   req_i  [NUM_REQ] : pending-request vector
//   last_i [ID_W]    : index granted last time
//   any_o            : at least one request pending
//   win_o  [ID_W]    : winning index (0 when nothing pending)
// ---------------------------------------------------------------------------
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic               any_o,
    output logic [ID_W-1:0]    win_o
);

    always_comb begin
        any_o = |req_i;
        win_o = '0;
        // Walk the lap backwards so the candidate closest to last_i+1 is
        // the final assignment and therefore the winner.
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = wrap_idx(int'(last_i) + k, NUM_REQ);
            if (req_i[idx]) begin
                win_o = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one 32-bit-word UART transmitter among NUM_REQ producers. Each
//   producer owns a one-entry holding slot; the arbiter grants pending slots
//   round-robin, pulses tx_valid for one cycle and waits for the frame to
//   finish (busy seen, then ready again) before the next grant.
//
//   clk        : clock
//   rst        : synchronous active-high reset
//   bus.slave  : in_data/in_valid/in_ready per producer,
//                tx_data/tx_valid/tx_busy/tx_ready to the transmitter,
//                grant_id (holds after completion), done (one-cycle pulse)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be within 2..%0d", MAX_REQ);
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    arb_st_t                        state_q, state_d;

    logic [NUM_REQ-1:0][WORD_W-1:0] slot_data_q;
    logic [NUM_REQ-1:0]             slot_valid_q, slot_valid_d;

    logic [ID_W-1:0]                last_grant_q, last_grant_d;
    logic [ID_W-1:0]                grant_id_q, grant_id_d;
    logic [WORD_W-1:0]              tx_data_q, tx_data_d;
    logic                           tx_valid_q, tx_valid_d;
    logic                           done_q, done_d;

    logic [NUM_REQ-1:0]             in_ready;
    logic [NUM_REQ-1:0]             load;
    logic                           any_pending;
    logic [ID_W-1:0]                winner;
    logic                           grant_fire;

    // -----------------------------------------------------------------------
    // Slot handshake and arbitration
    // -----------------------------------------------------------------------
    // Ready is forced low during reset so no producer believes a word was
    // taken on an edge that is about to clear the slots.
    assign in_ready = ~slot_valid_q & {NUM_REQ{~rst}};
    assign load     = bus.in_valid & in_ready;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i  (slot_valid_q),
        .last_i (last_grant_q),
        .any_o  (any_pending),
        .win_o  (winner)
    );

    // A grant needs the transmitter to be ready as well; another master may
    // still be attached to it.
    assign grant_fire = (state_q == IDLE) && any_pending && bus.tx_ready;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (grant_fire)   state_d = ISSUE;
            // The transmitter samples tx_valid on the edge leaving ISSUE.
            ISSUE:                        state_d = WAIT_START;
            WAIT_START: if (bus.tx_busy)  state_d = WAIT_DONE;
            WAIT_DONE:  if (bus.tx_ready) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output / datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        tx_valid_d   = grant_fire;
        done_d       = (state_q == WAIT_DONE) && bus.tx_ready;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        // A slot being loaded is never the one being granted: a full slot
        // has in_ready low, so set and clear never hit the same bit.
        slot_valid_d = slot_valid_q | load;
        if (grant_fire) begin
            tx_data_d            = slot_data_q[winner];
            grant_id_d           = winner;
            last_grant_d         = winner;
            slot_valid_d[winner] = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= '0;
            // Requester 0 is first in the search order after reset.
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            done_q       <= done_d;
        end
    end

    // Slot payloads carry no reset; slot_valid qualifies them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (load[i]) begin
                slot_data_q[i] <= bus.in_data[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Interface drive
    // -----------------------------------------------------------------------
    assign bus.in_ready = in_ready;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.grant_id = grant_id_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter with a behavioural 4-byte UART
//   transmitter (8N1, LSB first, BITC clocks per bit), a line receiver and
//   a scoreboard of expected words and bytes.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NREQ   = 4;
    localparam int IDW    = $clog2(NREQ);
    localparam int BITC   = 4;
    localparam int BUDGET = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0]    d;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_bytes[$];
    exp_t       mon_e;
    bit         in_flight  = 1'b0;
    bit         prev_valid = 1'b0;
    bit         prev_done  = 1'b0;
    int         done_cnt   = 0;
    int         rst_epoch  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural transmitter: accepts on data_valid && ready, raises busy,
    // shifts 40 line bits, drops busy, idles one cycle, then raises ready.
    // ------------------------------------------------------------------
    logic        m_ready, m_busy, m_gap, tx_line;
    logic        hold_low = 1'b0;
    logic [39:0] m_frame;
    int          m_bi, m_cnt;

    assign bus.tx_busy  = m_busy;
    assign bus.tx_ready = m_ready & ~hold_low;

    function automatic logic [39:0] frame_of(input logic [31:0] w);
        logic [39:0] f;
        for (int b = 0; b < 4; b++) f[10*b +: 10] = {1'b1, w[8*b +: 8], 1'b0};
        return f;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b1; m_busy <= 1'b0; m_gap <= 1'b0;
            tx_line <= 1'b1; m_bi <= 0; m_cnt <= 0;
        end else if (m_busy) begin
            if (m_cnt == BITC - 1) begin
                m_cnt <= 0;
                if (m_bi == 39) begin
                    m_busy <= 1'b0; m_gap <= 1'b1; tx_line <= 1'b1;
                end else begin
                    m_bi <= m_bi + 1; tx_line <= m_frame[m_bi + 1];
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (m_gap) begin
            m_gap <= 1'b0; m_ready <= 1'b1;
        end else if (bus.tx_valid && bus.tx_ready) begin
            m_frame <= frame_of(bus.tx_data);
            tx_line <= 1'b0; m_bi <= 0; m_cnt <= 0;
            m_busy  <= 1'b1; m_ready <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Line receiver: samples mid-bit, drops bytes cut by a reset.
    // ------------------------------------------------------------------
    initial begin : rx
        logic [7:0] b;
        logic       stopb;
        logic [7:0] eb;
        int         ep;
        forever begin
            @(negedge clk);
            if (tx_line === 1'b0) begin
                ep = rst_epoch;
                repeat (BITC + 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = tx_line;
                    if (i < 7) repeat (BITC) @(negedge clk);
                end
                repeat (BITC) @(negedge clk);
                stopb = tx_line;
                if (ep == rst_epoch) begin
                    chk("rx_stop_bit", 32'(stopb), 32'd1);
                    chk("rx_byte_expected", 32'(exp_bytes.size() > 0), 32'd1);
                    if (exp_bytes.size() > 0) begin
                        eb = exp_bytes.pop_front();
                        chk("rx_byte", 32'(b), 32'(eb));
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output monitor / scoreboard, sampled 1 time unit after each edge.
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        #1;
        if (rst) begin
            in_flight  = 1'b0;
            prev_valid = 1'b0;
            prev_done  = 1'b0;
            rst_epoch++;
        end else begin
            if (bus.tx_valid === 1'b1) begin
                chk("tx_valid_one_cycle", 32'(prev_valid), 32'd0);
                chk("tx_valid_before_done", 32'(in_flight), 32'd0);
                chk("tx_valid_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("tx_data", bus.tx_data, mon_e.d);
                    chk("grant_id", 32'(bus.grant_id), 32'(mon_e.id));
                    for (int b = 0; b < 4; b++) exp_bytes.push_back(mon_e.d[8*b +: 8]);
                end
                in_flight = 1'b1;
            end
            if (bus.done === 1'b1) begin
                chk("done_one_cycle", 32'(prev_done), 32'd0);
                chk("done_after_grant", 32'(in_flight), 32'd1);
                in_flight = 1'b0;
                done_cnt++;
            end
            prev_valid = (bus.tx_valid === 1'b1);
            prev_done  = (bus.done === 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic expect_word(input logic [31:0] d, input int id);
        exp_t e;
        e.d  = d;
        e.id = IDW'(id);
        exp_q.push_back(e);
    endtask

    task automatic send(input int i, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bus.in_data[i]  = d;
        bus.in_valid[i] = 1'b1;
        for (int t = 0; t < BUDGET && !ok; t++) begin
            if (bus.in_ready[i] === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 bus.in_valid[i] = 1'b0;
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic stream(input int i, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) send(i, base + 32'(k));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || exp_bytes.size() != 0 || in_flight ||
                bus.tx_ready !== 1'b1) && t < BUDGET) begin
            @(posedge clk); #2;
            t++;
        end
        chk("drain_in_time", 32'(t < BUDGET), 32'd1);
        chk("line_idle", 32'(tx_line), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        bus.in_valid = '0;
        @(negedge clk); rst = 1'b0;
        exp_q.delete();
        exp_bytes.delete();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : main
        int d0;
        bus.in_valid = '0;
        bus.in_data  = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", bus.tx_data, 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 chk("in_ready_after_rst", 32'(bus.in_ready), 32'((1 << NREQ) - 1));

        // Single word from requester 2
        d0 = done_cnt;
        expect_word(32'hDEADBEEF, 2);
        send(2, 32'hDEADBEEF);
        wait_drain();
        chk("single_done_count", 32'(done_cnt - d0), 32'd1);

        // All four load on the same edge
        do_reset();
        d0 = done_cnt;
        for (int i = 0; i < NREQ; i++) expect_word(32'h11111111 * 32'(i + 1), i);
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) bus.in_data[i] = 32'h11111111 * 32'(i + 1);
        bus.in_valid = '1;
        @(posedge clk); #1;
        bus.in_valid = '0;
        chk("all_loaded", 32'(bus.in_ready), 32'd0);
        wait_drain();
        chk("all_done_count", 32'(done_cnt - d0), 32'd4);

        // Fairness: requesters 0 and 3 streaming
        do_reset();
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            expect_word(32'h0A000000 + 32'(k), 0);
            expect_word(32'h3B000000 + 32'(k), 3);
        end
        fork
            stream(0, 32'h0A000000, 4);
            stream(3, 32'h3B000000, 4);
        join
        wait_drain();
        chk("fair_done_count", 32'(done_cnt - d0), 32'd8);

        // Backpressure on requester 1
        do_reset();
        d0 = done_cnt;
        expect_word(32'hCAFE0000, 1);
        expect_word(32'hCAFE0001, 1);
        @(negedge clk);
        bus.in_data[1]  = 32'hCAFE0000;
        bus.in_valid[1] = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_low_after_load", 32'(bus.in_ready[1]), 32'd0);
        bus.in_data[1] = 32'hCAFE0001;
        @(posedge clk); #1;
        chk("bp_grant_cycle_valid", 32'(bus.tx_valid), 32'd1);
        chk("bp_ready_high_in_grant", 32'(bus.in_ready[1]), 32'd1);
        @(posedge clk); #1;
        chk("bp_second_loaded", 32'(bus.in_ready[1]), 32'd0);
        bus.in_valid[1] = 1'b0;
        wait_drain();
        chk("bp_done_count", 32'(done_cnt - d0), 32'd2);

        // Reset during WAIT_DONE with slot 3 pending
        do_reset();
        d0 = done_cnt;
        expect_word(32'h55AA55AA, 0);
        send(0, 32'h55AA55AA);
        for (int t = 0; t < BUDGET && bus.tx_busy !== 1'b1; t++) @(posedge clk);
        chk("mid_busy_seen", 32'(bus.tx_busy), 32'd1);
        send(3, 32'h33333333);
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        exp_q.delete();
        exp_bytes.delete();
        #1 chk("mid_in_ready_all", 32'(bus.in_ready), 32'((1 << NREQ) - 1));
        repeat (300) @(posedge clk);
        #2;
        chk("mid_line_idle", 32'(tx_line), 32'd1);
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);

        // tx_ready held low in IDLE
        do_reset();
        d0 = done_cnt;
        @(negedge clk); hold_low = 1'b1;
        expect_word(32'h0BADF00D, 0);
        bus.in_data[0]  = 32'h0BADF00D;
        bus.in_valid[0] = 1'b1;
        @(posedge clk); #1;
        bus.in_valid[0] = 1'b0;
        chk("hold_loaded", 32'(bus.in_ready[0]), 32'd0);
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            chk("hold_no_tx_valid", 32'(bus.tx_valid), 32'd0);
        end
        @(negedge clk); hold_low = 1'b0;
        @(posedge clk); #1;
        chk("hold_grant_after_ready", 32'(bus.tx_valid), 32'd1);
        wait_drain();
        chk("hold_done_count", 32'(done_cnt - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
